// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule constants, key-length decoding and GF(2^8)/S-box helpers.
package aes_pkg;
    localparam int RK_W = 128;
    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;
    localparam logic [1:0] KL_RSV = 2'd3;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return kl == KL_256 ? 4'd8 : kl == KL_192 ? 4'd6 : 4'd4;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return kl == KL_128 ? 4'd10 : kl == KL_192 ? 4'd12 : 4'd14;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Entry b sits at bit 2047-8b, i.e. {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction
endpackage

// File: rtl/aes_key_schedule_gen_if.sv
// aes_key_schedule_gen_if: key-load request and round-key stream between the schedule and its neighbours.
interface aes_key_schedule_gen_if;
    import aes_pkg::*;
    logic            flush;
    logic            start_valid;
    logic            start_ready;
    logic [1:0]      key_len;
    logic [255:0]    key_in;
    logic            cfg_err;
    logic            rk_valid;
    logic            rk_ready;
    logic [RK_W-1:0] rk_data;
    logic [3:0]      rk_index;
    logic            rk_last;
    logic            busy;

    modport slave (
        input  flush, start_valid, key_len, key_in, rk_ready,
        output start_ready, cfg_err, rk_valid, rk_data, rk_index, rk_last, busy
    );
    modport master (
        output flush, start_valid, key_len, key_in, rk_ready,
        input  start_ready, cfg_err, rk_valid, rk_data, rk_index, rk_last, busy
    );
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: byte-wise AES S-box substitution of one 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);
    for (genvar g = 0; g < 4; g++) begin : g_sb
        assign result[8*g +: 8] = sbox(word[8*g +: 8]);
    end
endmodule

// File: rtl/aes_key_schedule_gen.sv
// aes_key_schedule_gen: word-serial AES-128/192/256 key expansion, one schedule word per cycle,
// emitting round keys 0..Nr on a valid/ready stream.
module aes_key_schedule_gen
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int IDX_W = 4
) (
    input logic clk,
    input logic rst_n,
    aes_key_schedule_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic up;
    logic [5:0] i;
    logic [2:0] j;
    logic [3:0] nk, nr;
    logic [7:0] rcon;
    logic [255:0] key_q;
    logic [31:0] win [MAX_NK];
    logic [31:0] acc [3];
    logic [31:0] sub_in, sub_out, temp, w;
    logic [RK_W-1:0] rk_data;
    logic [IDX_W-1:0] rk_index;
    logic rk_valid, rk_last, cfg_err;
    logic accept, advance, group_end, last_word, handshake;

    aes_sub_word u_sub (.word(sub_in), .result(sub_out));

    assign bus.start_ready = up && state == IDLE && !bus.flush;
    assign bus.busy = state != IDLE;
    assign bus.rk_valid = rk_valid;
    assign bus.rk_data = rk_data;
    assign bus.rk_index = rk_index;
    assign bus.rk_last = rk_last;
    assign bus.cfg_err = cfg_err;
    assign accept = bus.start_valid && bus.start_ready && bus.key_len != KL_RSV;
    assign handshake = rk_valid && bus.rk_ready;
    assign group_end = i[1:0] == 2'd3;
    // The 4th word of a group needs the output register free; a same-cycle handshake frees it.
    assign advance = state == RUN && !bus.flush && !(group_end && rk_valid && !bus.rk_ready);
    assign last_word = i == {nr, 2'b11};

    // j tracks i mod Nk; win[0] is w[i-1] and win[Nk-1] is w[i-Nk].
    always_comb begin
        sub_in = j == 3'd0 ? {win[0][23:0], win[0][31:24]} : win[0];
        temp = j == 3'd0 ? sub_out ^ {rcon, 24'h0} : (nk == 4'd8 && j == 3'd4) ? sub_out : win[0];
        w = i < {2'b00, nk} ? key_q[255:224] : win[3'(nk - 4'd1)] ^ temp;
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) state_nx = IDLE;
        else if (accept) state_nx = RUN;
        else if (advance && last_word) state_nx = DRAIN;
        else if (state == DRAIN && handshake) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up <= 1'b0;
            i <= '0;
            j <= '0;
            nk <= '0;
            nr <= '0;
            rcon <= 8'h01;
            key_q <= '0;
            win <= '{default: '0};
            acc <= '{default: '0};
            rk_data <= '0;
            rk_index <= '0;
            rk_last <= 1'b0;
            rk_valid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            up <= 1'b1;
            cfg_err <= bus.start_valid && bus.start_ready && bus.key_len == KL_RSV;
            if (handshake || bus.flush) begin
                rk_valid <= 1'b0;
                rk_last <= 1'b0;
            end
            if (accept) begin
                key_q <= bus.key_in;
                nk <= nk_of(bus.key_len);
                nr <= nr_of(bus.key_len);
                i <= '0;
                j <= '0;
                rcon <= 8'h01;
            end else if (advance) begin
                key_q <= key_q << 32;
                win[0] <= w;
                for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
                i <= i + 6'd1;
                j <= {1'b0, j} == nk - 4'd1 ? 3'd0 : j + 3'd1;
                if (j == 3'd0 && i >= {2'b00, nk}) rcon <= xtime(rcon);
                if (group_end) begin
                    rk_data <= {acc[0], acc[1], acc[2], w};
                    rk_valid <= 1'b1;
                    rk_index <= IDX_W'(i[5:2]);
                    rk_last <= last_word;
                end else begin
                    acc[i[1:0]] <= w;
                end
            end
        end
    end
endmodule
